// File: rtl/param_fifo_pkg.sv
// Shared constants for the parameterised synchronous FIFO: read-mode selectors
// and default geometry.
package param_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 1024;

    // Occupancy needs one bit more than the address so that "full" is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/param_fifo_ram.sv
// Simple dual-port storage array: one synchronous write port and one read port
// that is either registered (with enable) or asynchronous.
module param_fifo_ram #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 1024,
    parameter int REG_READ = 1,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset on purpose; clearing it would force flops
    // instead of RAM and the FIFO pointers already make stale words unreachable.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    generate
        if (REG_READ != 0) begin : g_reg_read
            logic [DATA_W-1:0] r_rdata;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rdata <= '0;
                end else if (re) begin
                    r_rdata <= r_mem[raddr];
                end
            end

            assign rdata = r_rdata;
        end else begin : g_async_read
            logic w_unused_ctrl;

            assign rdata         = r_mem[raddr];
            assign w_unused_ctrl = ^{rst, re};
        end
    endgenerate

endmodule

// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy counter, threshold flags, sticky error flags
// and a choice of registered or first-word-fall-through read.
module param_sync_fifo
    import param_fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4,
    parameter int FWFT      = FIFO_STD
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic                     err_clr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = cnt_width(DEPTH);

    localparam logic [CNT_W-1:0]  L_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  L_AF    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0]  L_AE    = CNT_W'(AE_THRESH);
    localparam logic [ADDR_W-1:0] L_ONE   = ADDR_W'(1);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [DATA_W-1:0] w_ram_rdata;

    // Flags decode only the count register, so request inputs never reach them.
    assign w_full       = (r_count == L_DEPTH);
    assign w_empty      = (r_count == '0);
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= L_AF);
    assign almost_empty = (r_count <= L_AE);
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    assign w_wr_acc = wr_en && !w_full;
    assign w_rd_acc = rd_en && !w_empty;

    // NOTE: every state register uses non-blocking assignment so all updates see
    // the pre-edge values of count and the pointers, regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + L_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + L_ONE;
            end
            r_count <= r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);
        end
    end

    // Clearing wins over a same-cycle set so software never misses its own clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (err_clr) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    param_fifo_ram #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .REG_READ ((FWFT == FIFO_STD) ? 1 : 0)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (w_wr_acc),
        .waddr (r_wr_ptr),
        .wdata (wr_data),
        .re    (w_rd_acc),
        .raddr (r_rd_ptr),
        .rdata (w_ram_rdata)
    );

    generate
        if (FWFT == FIFO_FWFT) begin : g_fwft
            // Head word is presented directly; masked while empty so stale data never shows.
            assign rd_data  = w_empty ? '0 : w_ram_rdata;
            assign rd_valid = !w_empty;
        end else begin : g_std
            logic r_rd_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                end
            end

            assign rd_data  = w_ram_rdata;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Scoreboard bench for param_sync_fifo: a registered-read and a FWFT instance share
// the same stimulus; expected words are queued on accepted writes and popped on reads.
module tb_param_sync_fifo;
    import param_fifo_pkg::*;

    localparam int DW = 8;
    localparam int DP = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, wr_en, rd_en, err_clr;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] s_rd_data, f_rd_data;
    logic          s_rd_valid, f_rd_valid;
    logic          s_empty, s_full, s_ae, s_af, s_ovf, s_udf;
    logic          f_empty, f_full, f_ae, f_af, f_ovf, f_udf;
    logic [CW-1:0] s_count, f_count;

    int            m_count;
    bit            m_ovf, m_udf, m_rd;
    logic [DW-1:0] m_exp;
    logic [DW-1:0] sb[$];
    int            n_checks = 0;
    int            n_pass   = 0;

    always #5 clk = ~clk;

    param_sync_fifo #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(6), .AE_THRESH(1), .FWFT(FIFO_STD)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .err_clr(err_clr),
        .rd_data(s_rd_data), .rd_valid(s_rd_valid), .empty(s_empty), .full(s_full),
        .almost_empty(s_ae), .almost_full(s_af), .count(s_count), .overflow(s_ovf), .underflow(s_udf));

    param_sync_fifo #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(6), .AE_THRESH(1), .FWFT(FIFO_FWFT)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .err_clr(err_clr),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .empty(f_empty), .full(f_full),
        .almost_empty(f_ae), .almost_full(f_af), .count(f_count), .overflow(f_ovf), .underflow(f_udf));

    // One clock of stimulus; the model predicts acceptance from its own occupancy.
    task automatic drive(input bit r, input bit w, input logic [DW-1:0] d, input bit rd, input bit clr);
        bit wa, ra;
        rst = r; wr_en = w; wr_data = d; rd_en = rd; err_clr = clr;
        m_rd = 1'b0;
        if (r) begin
            m_count = 0; m_ovf = 1'b0; m_udf = 1'b0;
            sb.delete();
        end else begin
            wa = w && (m_count < DP);
            ra = rd && (m_count > 0);
            if (clr) begin
                m_ovf = 1'b0; m_udf = 1'b0;
            end else begin
                if (w && m_count == DP) m_ovf = 1'b1;
                if (rd && m_count == 0) m_udf = 1'b1;
            end
            if (ra) begin
                m_exp = sb.pop_front();
                m_rd  = 1'b1;
                m_count--;
            end
            if (wa) begin
                sb.push_back(d);
                m_count++;
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset();
        drive(1, 0, 8'h00, 0, 0);
        n_checks++; if (s_count !== 4'd0) $display("FAIL reset_count: got %0d exp 0", s_count); else n_pass++;
        n_checks++; if (s_empty !== 1'b1) $display("FAIL reset_empty: got %b exp 1", s_empty); else n_pass++;
        n_checks++; if (s_full !== 1'b0) $display("FAIL reset_full: got %b exp 0", s_full); else n_pass++;
        n_checks++; if (s_ae !== 1'b1) $display("FAIL reset_almost_empty: got %b exp 1", s_ae); else n_pass++;
        n_checks++; if (s_af !== 1'b0) $display("FAIL reset_almost_full: got %b exp 0", s_af); else n_pass++;
        n_checks++; if ({s_ovf, s_udf} !== 2'b00) $display("FAIL reset_errors: got %b%b exp 00", s_ovf, s_udf); else n_pass++;
        n_checks++; if (s_rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b exp 0", s_rd_valid); else n_pass++;
        n_checks++; if (s_rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h exp 00", s_rd_data); else n_pass++;
        n_checks++; if (f_rd_valid !== 1'b0) $display("FAIL reset_fwft_rd_valid: got %b exp 0", f_rd_valid); else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DP; i++) begin
            drive(0, 1, 8'(i), 0, 0);
            n_checks++; if (s_count !== 4'(i)) $display("FAIL fill_count: got %0d exp %0d", s_count, i); else n_pass++;
            n_checks++; if (s_af !== (i >= 6)) $display("FAIL fill_almost_full@%0d: got %b exp %b", i, s_af, (i >= 6)); else n_pass++;
            n_checks++; if (s_full !== (i == DP)) $display("FAIL fill_full@%0d: got %b exp %b", i, s_full, (i == DP)); else n_pass++;
            n_checks++; if (s_empty !== 1'b0) $display("FAIL fill_empty@%0d: got %b exp 0", i, s_empty); else n_pass++;
        end
        drive(0, 1, 8'hFF, 0, 0);
        n_checks++; if (s_ovf !== 1'b1) $display("FAIL fill_overflow: got %b exp 1", s_ovf); else n_pass++;
        n_checks++; if (s_count !== 4'd8) $display("FAIL fill_count_after_overflow: got %0d exp 8", s_count); else n_pass++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < DP; i++) begin
            drive(0, 0, 8'h00, 1, 0);
            n_checks++; if (s_rd_valid !== m_rd) $display("FAIL drain_rd_valid@%0d: got %b exp %b", i, s_rd_valid, m_rd); else n_pass++;
            if (m_rd) begin
                n_checks++; if (s_rd_data !== m_exp) $display("FAIL drain_rd_data@%0d: got %h exp %h", i, s_rd_data, m_exp); else n_pass++;
            end
            n_checks++; if (s_ae !== (m_count <= 1)) $display("FAIL drain_almost_empty@%0d: got %b exp %b", i, s_ae, (m_count <= 1)); else n_pass++;
        end
        n_checks++; if (s_empty !== 1'b1) $display("FAIL drain_empty: got %b exp 1", s_empty); else n_pass++;
        drive(0, 0, 8'h00, 0, 0);
        n_checks++; if (s_rd_valid !== 1'b0) $display("FAIL drain_idle_rd_valid: got %b exp 0", s_rd_valid); else n_pass++;
        n_checks++; if (s_rd_data !== 8'h08) $display("FAIL drain_hold_rd_data: got %h exp 08", s_rd_data); else n_pass++;
        drive(0, 0, 8'h00, 1, 0);
        n_checks++; if (s_udf !== 1'b1) $display("FAIL drain_underflow: got %b exp 1", s_udf); else n_pass++;
        n_checks++; if (s_rd_valid !== 1'b0) $display("FAIL drain_underflow_rd_valid: got %b exp 0", s_rd_valid); else n_pass++;
        n_checks++; if (s_count !== 4'd0) $display("FAIL drain_underflow_count: got %0d exp 0", s_count); else n_pass++;
    endtask

    task automatic test_wrap();
        drive(0, 0, 8'h00, 0, 1);
        n_checks++; if ({s_ovf, s_udf} !== {m_ovf, m_udf}) $display("FAIL wrap_err_clr: got %b%b exp %b%b", s_ovf, s_udf, m_ovf, m_udf); else n_pass++;
        for (int rep = 0; rep < 4; rep++) begin
            for (int k = 0; k < 5; k++) drive(0, 1, 8'(8'h10 + rep * 16 + k), 0, 0);
            for (int k = 0; k < 5; k++) begin
                drive(0, 0, 8'h00, 1, 0);
                n_checks++; if (s_rd_valid !== 1'b1 || s_rd_data !== m_exp)
                    $display("FAIL wrap_data r%0d k%0d: got %b/%h exp 1/%h", rep, k, s_rd_valid, s_rd_data, m_exp);
                else n_pass++;
            end
        end
        n_checks++; if (s_count !== 4'd0) $display("FAIL wrap_final_count: got %0d exp 0", s_count); else n_pass++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DP; i++) drive(0, 1, 8'(8'h40 + i), 0, 0);
        drive(0, 1, 8'hEE, 1, 0);
        n_checks++; if (s_count !== 4'd7) $display("FAIL b2b_full_count: got %0d exp 7", s_count); else n_pass++;
        n_checks++; if (s_rd_valid !== 1'b1 || s_rd_data !== 8'h40) $display("FAIL b2b_full_read: got %b/%h exp 1/40", s_rd_valid, s_rd_data); else n_pass++;
        for (int i = 0; i < DP - 1; i++) begin
            drive(0, 0, 8'h00, 1, 0);
            n_checks++; if (s_rd_data !== m_exp) $display("FAIL b2b_drain@%0d: got %h exp %h", i, s_rd_data, m_exp); else n_pass++;
        end
        n_checks++; if (s_empty !== 1'b1) $display("FAIL b2b_rejected_write_stored: empty got %b exp 1", s_empty); else n_pass++;
        drive(0, 1, 8'h77, 1, 0);
        n_checks++; if (s_count !== 4'd1) $display("FAIL b2b_empty_count: got %0d exp 1", s_count); else n_pass++;
        n_checks++; if (s_rd_valid !== 1'b0) $display("FAIL b2b_empty_rd_valid: got %b exp 0", s_rd_valid); else n_pass++;
        drive(0, 0, 8'h00, 1, 0);
        n_checks++; if (s_rd_data !== 8'h77) $display("FAIL b2b_empty_word: got %h exp 77", s_rd_data); else n_pass++;
    endtask

    task automatic test_fwft();
        drive(1, 0, 8'h00, 0, 0);
        n_checks++; if (f_empty !== 1'b1 || f_rd_valid !== 1'b0) $display("FAIL fwft_reset: got %b/%b exp 1/0", f_empty, f_rd_valid); else n_pass++;
        drive(0, 1, 8'hA5, 0, 0);
        n_checks++; if (f_empty !== 1'b0) $display("FAIL fwft_empty: got %b exp 0", f_empty); else n_pass++;
        n_checks++; if (f_rd_valid !== 1'b1) $display("FAIL fwft_rd_valid: got %b exp 1", f_rd_valid); else n_pass++;
        n_checks++; if (f_rd_data !== 8'hA5) $display("FAIL fwft_rd_data: got %h exp a5", f_rd_data); else n_pass++;
        n_checks++; if (s_rd_valid !== 1'b0) $display("FAIL fwft_std_no_read: got %b exp 0", s_rd_valid); else n_pass++;
        drive(0, 1, 8'h11, 1, 0);
        n_checks++; if (s_rd_data !== 8'hA5) $display("FAIL fwft_std_pop: got %h exp a5", s_rd_data); else n_pass++;
        drive(0, 1, 8'h22, 0, 0);
        n_checks++; if (f_rd_data !== 8'h11) $display("FAIL fwft_head1: got %h exp 11", f_rd_data); else n_pass++;
        drive(0, 0, 8'h00, 1, 0);
        n_checks++; if (f_rd_data !== 8'h22) $display("FAIL fwft_head2: got %h exp 22", f_rd_data); else n_pass++;
        drive(0, 0, 8'h00, 1, 0);
        n_checks++; if (f_empty !== 1'b1 || f_rd_valid !== 1'b0) $display("FAIL fwft_drained: got %b/%b exp 1/0", f_empty, f_rd_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < DP; i++) drive(0, 1, 8'(8'h60 + i), 0, 0);
        drive(0, 1, 8'hFF, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 0, 8'h00, 1, 0);
        n_checks++; if (s_count !== 4'd5 || s_ovf !== 1'b1) $display("FAIL mid_pre_state: got %0d/%b exp 5/1", s_count, s_ovf); else n_pass++;
        drive(1, 1, 8'h99, 1, 1);
        n_checks++; if (s_count !== 4'd0) $display("FAIL mid_reset_count: got %0d exp 0", s_count); else n_pass++;
        n_checks++; if (s_empty !== 1'b1) $display("FAIL mid_reset_empty: got %b exp 1", s_empty); else n_pass++;
        n_checks++; if (s_ovf !== 1'b0) $display("FAIL mid_reset_overflow: got %b exp 0", s_ovf); else n_pass++;
        n_checks++; if (f_rd_valid !== 1'b0) $display("FAIL mid_reset_stale_head: got %b exp 0", f_rd_valid); else n_pass++;
        drive(0, 1, 8'h3C, 0, 0);
        drive(0, 0, 8'h00, 1, 0);
        n_checks++; if (s_rd_data !== 8'h3C) $display("FAIL mid_post_reset_word: got %h exp 3c", s_rd_data); else n_pass++;
        for (int i = 0; i < DP; i++) drive(0, 1, 8'(8'h50 + i), 0, 0);
        drive(0, 1, 8'hFF, 0, 0);
        drive(0, 0, 8'h00, 0, 1);
        n_checks++; if (s_ovf !== 1'b0 || s_count !== 4'd8) $display("FAIL mid_clr_overflow: got %b/%0d exp 0/8", s_ovf, s_count); else n_pass++;
        drive(0, 1, 8'hFF, 0, 1);
        n_checks++; if (s_ovf !== 1'b0) $display("FAIL mid_clr_priority: got %b exp 0", s_ovf); else n_pass++;
        for (int i = 0; i < DP; i++) begin
            drive(0, 0, 8'h00, 1, 0);
            n_checks++; if (s_rd_data !== m_exp) $display("FAIL mid_drain@%0d: got %h exp %h", i, s_rd_data, m_exp); else n_pass++;
        end
        drive(0, 0, 8'h00, 1, 0);
        n_checks++; if (s_udf !== 1'b1) $display("FAIL mid_underflow: got %b exp 1", s_udf); else n_pass++;
        drive(0, 0, 8'h00, 0, 1);
        n_checks++; if (s_udf !== 1'b0 || s_count !== 4'd0) $display("FAIL mid_clr_underflow: got %b/%0d exp 0/0", s_udf, s_count); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_back_to_back();
        test_fwft();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
